// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, S-box tables and lane-count legality helper
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sb_state_t;

  localparam logic [7:0] AES_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] AES_INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // A lane count is usable only if it splits the 16-byte state evenly as a power of two
  function automatic bit lanes_legal(input int lanes);
    return (lanes > 0) && (lanes <= 16) && ((16 % lanes) == 0) && ((lanes & (lanes - 1)) == 0);
  endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// rtl/aes_sbox_lane.sv - one combinational forward/inverse S-box byte lookup
module aes_sbox_lane
  import aes_pkg::*;
#(
  parameter bit INV_EN = 1'b1
) (
  input  logic [7:0] a,
  input  logic       inv,
  output logic [7:0] c
);

  // With INV_EN cleared the inverse table is constant-folded away and inv is ignored
  assign c = (INV_EN && inv) ? AES_INV_SBOX[a] : AES_SBOX[a];

endmodule

// File: rtl/aes_sub_bytes_engine.sv
// rtl/aes_sub_bytes_engine.sv - multi-cycle SubBytes/InvSubBytes engine, LANES bytes per clock
module aes_sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int LANES  = 4,
  parameter bit INV_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (!lanes_legal(LANES)) begin : g_bad_lanes
    $error("aes_sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  sb_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [15:0][7:0]     work_q, work_d;
  logic                 mode_q, mode_d;

  logic [LANES-1:0][3:0] lane_idx;
  logic [LANES-1:0][7:0] lane_a;
  logic [LANES-1:0][7:0] lane_c;

  // Byte positions handled this cycle: group cnt covers cnt*LANES .. cnt*LANES+LANES-1
  always_comb begin
    lane_idx = '0;
    lane_a   = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l] = 4'(int'(cnt_q) * LANES + l);
      lane_a[l]   = work_q[lane_idx[l]];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_sbox_lane #(.INV_EN(INV_EN)) u_lane (
      .a   (lane_a[g]),
      .inv (mode_q),
      .c   (lane_c[g])
    );
  end

  // Next-state, counter, mode and in-place write-back of the substituted group
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          mode_d  = INV_EN ? in_inv : 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int l = 0; l < LANES; l++) begin
          work_d[lane_idx[l]] = lane_c[l];
        end
        if (cnt_q == CW'(N - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset takes effect immediately in any state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      mode_q  <= mode_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = work_q;

endmodule

// File: tb/tb_aes_sub_bytes_engine.sv
// tb/tb_aes_sub_bytes_engine.sv - self-checking bench for aes_sub_bytes_engine across lane/inverse builds
module tb_aes_sub_bytes_engine;

  localparam logic [127:0] FIPS_IN  = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
  localparam logic [127:0] FIPS_OUT = 128'h3052411ee55db4b8f198bfe0ae1127d4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [127:0] in_data = '0;
  logic in_inv = 1'b0;
  logic out_ready = 1'b0;
  int sel = 0;

  logic [3:0] in_ready_v, out_valid_v, busy_v;
  logic [127:0] out_data_v [4];

  logic cur_in_ready, cur_out_valid, cur_busy;
  logic [127:0] cur_out_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] fwd_tbl [256];
  logic [7:0] inv_tbl [256];

  always #5 clk = ~clk;

  // dut 0: LANES=4, dut 1: LANES=1, dut 2: LANES=16, dut 3: LANES=4 with no inverse tables
  aes_sub_bytes_engine #(.LANES(4), .INV_EN(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 0), .in_ready(in_ready_v[0]),
    .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid_v[0]), .out_ready(out_ready && sel == 0),
    .out_data(out_data_v[0]), .busy(busy_v[0]));
  aes_sub_bytes_engine #(.LANES(1), .INV_EN(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 1), .in_ready(in_ready_v[1]),
    .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid_v[1]), .out_ready(out_ready && sel == 1),
    .out_data(out_data_v[1]), .busy(busy_v[1]));
  aes_sub_bytes_engine #(.LANES(16), .INV_EN(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 2), .in_ready(in_ready_v[2]),
    .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid_v[2]), .out_ready(out_ready && sel == 2),
    .out_data(out_data_v[2]), .busy(busy_v[2]));
  aes_sub_bytes_engine #(.LANES(4), .INV_EN(1'b0)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 3), .in_ready(in_ready_v[3]),
    .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid_v[3]), .out_ready(out_ready && sel == 3),
    .out_data(out_data_v[3]), .busy(busy_v[3]));

  always_comb begin
    cur_in_ready  = in_ready_v[sel[1:0]];
    cur_out_valid = out_valid_v[sel[1:0]];
    cur_busy      = busy_v[sel[1:0]];
    cur_out_data  = out_data_v[sel[1:0]];
  end

  function automatic int cycles_of(input int s);
    return (s == 1) ? 16 : (s == 2) ? 1 : 4;
  endfunction

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map
  function automatic logic [7:0] sbox_math(input logic [7:0] v);
    logic [7:0] r, b;
    r = 8'h01;
    if (v == 8'h00) r = 8'h00;
    else for (int i = 0; i < 254; i++) r = gmul(r, v);
    b = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    return b;
  endfunction

  function automatic logic [127:0] model_block(input logic [127:0] d, input logic inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv ? inv_tbl[d[8*i +: 8]] : fwd_tbl[d[8*i +: 8]];
    return r;
  endfunction

  task automatic do_block(input logic [127:0] d, input logic inv, input bit toggle,
                          output logic [127:0] res, output int lat);
    @(negedge clk);
    checks++;
    if (cur_in_ready !== 1'b1) begin
      errors++; $display("FAIL accept_ready sel=%0d in_ready=%b expected 1", sel, cur_in_ready);
    end
    in_valid = 1'b1; in_data = d; in_inv = inv;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = {$urandom, $urandom, $urandom, $urandom};
    lat = 0;
    while (cur_out_valid !== 1'b1 && lat < 40) begin
      if (toggle) in_inv = ~in_inv;
      @(posedge clk); #1;
      lat++;
    end
    res = cur_out_data;
  endtask

  task automatic finish_block();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (cur_out_valid !== 1'b0 || cur_in_ready !== 1'b1 || cur_busy !== 1'b0) begin
      errors++;
      $display("FAIL release sel=%0d out_valid=%b in_ready=%b busy=%b expected 0/1/0",
               sel, cur_out_valid, cur_in_ready, cur_busy);
    end
  endtask

  task automatic run_and_check(input string name, input logic [127:0] d, input logic inv,
                               input logic [127:0] exp, input bit toggle);
    logic [127:0] res;
    int lat;
    do_block(d, inv, toggle, res, lat);
    checks++;
    if (lat !== cycles_of(sel)) begin
      errors++; $display("FAIL %s_latency sel=%0d got %0d expected %0d", name, sel, lat, cycles_of(sel));
    end
    checks++;
    if (res !== exp) begin
      errors++; $display("FAIL %s_data sel=%0d got %h expected %h", name, sel, res, exp);
    end
    finish_block();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (in_ready_v[s] !== 1'b1 || out_valid_v[s] !== 1'b0 || busy_v[s] !== 1'b0 || out_data_v[s] !== '0) begin
        errors++;
        $display("FAIL reset dut=%0d in_ready=%b out_valid=%b busy=%b out_data=%h expected 1/0/0/0",
                 s, in_ready_v[s], out_valid_v[s], busy_v[s], out_data_v[s]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fips();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      run_and_check("fips_fwd", FIPS_IN, 1'b0, FIPS_OUT, 1'b0);
      run_and_check("fips_inv", FIPS_OUT, 1'b1, FIPS_IN, 1'b0);
    end
    sel = 0;
  endtask

  task automatic test_corners();
    sel = 0;
    run_and_check("zero", '0, 1'b0, {16{8'h63}}, 1'b0);
    run_and_check("ones", {16{8'hff}}, 1'b0, {16{8'h16}}, 1'b0);
    run_and_check("inv63", {16{8'h63}}, 1'b1, '0, 1'b0);
  endtask

  task automatic test_random();
    logic [127:0] d;
    logic inv;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int k = 0; k < 6; k++) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        inv = 1'($urandom_range(0, 1));
        run_and_check("random", d, inv, model_block(d, inv), 1'b0);
      end
    end
    sel = 0;
  endtask

  task automatic test_backpressure();
    logic [127:0] res;
    int lat;
    sel = 0;
    do_block(FIPS_IN, 1'b0, 1'b0, res, lat);
    in_valid = 1'b1; in_data = '0; in_inv = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (cur_out_valid !== 1'b1 || cur_in_ready !== 1'b0 || cur_out_data !== FIPS_OUT) begin
        errors++;
        $display("FAIL backpressure cycle=%0d out_valid=%b in_ready=%b out_data=%h expected 1/0/%h",
                 c, cur_out_valid, cur_in_ready, cur_out_data, FIPS_OUT);
      end
    end
    in_valid = 1'b0;
    finish_block();
  endtask

  task automatic test_mode_toggle();
    sel = 0;
    run_and_check("toggle_fwd", FIPS_IN, 1'b0, FIPS_OUT, 1'b1);
    sel = 1;
    run_and_check("toggle_inv", FIPS_OUT, 1'b1, FIPS_IN, 1'b1);
    sel = 0;
  endtask

  task automatic test_reset_mid();
    sel = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = FIPS_IN; in_inv = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (cur_out_valid !== 1'b0 || cur_in_ready !== 1'b1 || cur_out_data !== '0 || cur_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid out_valid=%b in_ready=%b busy=%b out_data=%h expected 0/1/0/0",
               cur_out_valid, cur_in_ready, cur_busy, cur_out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_and_check("after_reset", FIPS_IN, 1'b0, FIPS_OUT, 1'b0);
  endtask

  task automatic test_inv_disabled();
    sel = 3;
    run_and_check("inv_disabled_zero", '0, 1'b1, {16{8'h63}}, 1'b0);
    run_and_check("inv_disabled_fips", FIPS_IN, 1'b1, FIPS_OUT, 1'b0);
    sel = 0;
  endtask

  initial begin
    for (int v = 0; v < 256; v++) fwd_tbl[v] = sbox_math(8'(v));
    for (int v = 0; v < 256; v++) inv_tbl[fwd_tbl[v]] = 8'(v);
    test_reset();
    test_fips();
    test_corners();
    test_random();
    test_backpressure();
    test_mode_toggle();
    test_reset_mid();
    test_inv_disabled();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
